// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter/mux.
package mux8_arb_pkg;
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/mux8_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after base, wrapping 7->0.
module mux8_rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] base,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // The 3-bit sum wraps naturally, giving the rotating scan order.
        for (int k = 0; k < N_REQ; k++) begin
            cand = base + SEL_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// 8-requester round-robin arbiter with bounded hold and a registered 8:1 data mux.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]        gnt,
    output logic [SEL_W-1:0]        sel,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       data_out,
    output logic                    busy
);
    state_t            state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic              out_valid_nxt;
    logic [DATA_W-1:0] data_out_nxt;

    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic [DATA_W-1:0] lane [N_REQ];
    logic [DATA_W-1:0] lane_sel;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane[i] = data_in[i*DATA_W +: DATA_W];
    end

    // Mux select comes from the registered grant index, never the live scan.
    assign lane_sel = lane[sel];
    assign busy     = (state == GRANT);

    mux8_rr_pick u_pick (
        .req   (req),
        .base  (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            sel       <= sel_nxt;
            out_valid <= out_valid_nxt;
            data_out  <= data_out_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt;
        gnt_nxt       = gnt;
        sel_nxt       = sel;
        out_valid_nxt = 1'b0;
        data_out_nxt  = data_out;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (pick_found) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick_idx;
                    gnt_nxt   = N_REQ'(1) << pick_idx;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (req[sel]) begin
                    out_valid_nxt = 1'b1;
                    data_out_nxt  = lane_sel;
                    if (cnt == 4'(HOLD_MAX - 1)) begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        ptr_nxt   = sel + SEL_W'(1);
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end else begin
                    // Requester let go: release and move priority past it.
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = sel + SEL_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
